unified_cache_mem_responder: RTL and testbench



---
 rtl/unified_cache_mem_responder.sv | 156 +++++++++++++++
 tb/tb_unified_cache_mem_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_cache_mem_responder.sv
// Main-memory endpoint for the unified cache: captures miss/writeback packets,
// services reads from a block store after a fixed latency, returns fill packets.
`timescale 1ns/1ps

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 69
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 68
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI 67
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO 65
`endif
`ifndef UNIFIED_CACHE_PACKET_IS_WRITE_POS
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS 64
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_HI
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI 63
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_LO
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO 32
`endif
`ifndef UNIFIED_CACHE_PACKET_DATA_POS_LO
`define UNIFIED_CACHE_PACKET_DATA_POS_LO 0
`endif

module unified_cache_mem_responder #(
  parameter int NUM_BLOCKS                         = 256,
  parameter int BLOCK_SIZE_IN_BYTES                = 4,
  parameter int LATENCY                            = 4,
  parameter int QUEUE_DEPTH                        = 4,
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] to_mem_packet_in,
  output logic                                          to_mem_packet_ack_out,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] from_mem_packet_out,
  input  logic                                          from_mem_packet_ack_in
);

  localparam int PKT_W        = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int DATA_W       = BLOCK_SIZE_IN_BYTES * 8;
  localparam int OFFSET_W     = $clog2(BLOCK_SIZE_IN_BYTES);
  localparam int INDEX_W      = $clog2(NUM_BLOCKS);
  localparam int PTR_W        = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QCNT_W       = $clog2(QUEUE_DEPTH + 1);
  localparam int LAT_W        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int VALID_POS    = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int IS_WRITE_POS = `UNIFIED_CACHE_PACKET_IS_WRITE_POS;
  localparam int ADDR_LO      = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
  localparam int DATA_LO      = `UNIFIED_CACHE_PACKET_DATA_POS_LO;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [LAT_W-1:0]         cnt_q, cnt_d;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [QCNT_W-1:0]        q_count_q;
  logic                     ack_p1;
  logic [PKT_W-1:0]         hold_pkt_p1;
  logic [PKT_W-1:0]         queue_q [QUEUE_DEPTH];
  logic [DATA_W-1:0]        store_q [NUM_BLOCKS];

  logic                     req_vld;
  logic                     req_write;
  logic                     wr_en;
  logic                     push;
  logic                     pop;
  logic [INDEX_W-1:0]       req_index;
  logic [PKT_W-1:0]         rsp_pkt;

  // Capture stage: the cycle after an ack is blind so one packet is never taken twice.
  always_comb begin
    req_vld   = to_mem_packet_in[VALID_POS] && !ack_p1;
    req_write = to_mem_packet_in[IS_WRITE_POS];
    req_index = to_mem_packet_in[ADDR_LO + OFFSET_W +: INDEX_W];
    wr_en     = req_vld && req_write;
    push      = req_vld && !req_write && (q_count_q < QCNT_W'(QUEUE_DEPTH));
    rsp_pkt                       = to_mem_packet_in;
    rsp_pkt[DATA_LO +: DATA_W]    = store_q[req_index];
    rsp_pkt[IS_WRITE_POS]         = 1'b0;
    rsp_pkt[VALID_POS]            = 1'b1;
  end

  // Service stage: WAIT always runs LATENCY cycles so a fill appears LATENCY+1 after its ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (q_count_q != '0) begin
          pop     = 1'b1;
          cnt_d   = LAT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = SEND;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      SEND: begin
        if (from_mem_packet_ack_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      q_count_q <= '0;
      ack_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_p1  <= wr_en || push;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   q_count_q <= q_count_q + QCNT_W'(1);
        2'b01:   q_count_q <= q_count_q - QCNT_W'(1);
        default: q_count_q <= q_count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_BLOCKS; i++) store_q[i] <= '0;
    end else if (wr_en) begin
      store_q[req_index] <= to_mem_packet_in[DATA_LO +: DATA_W];
    end
  end

  // Read data was frozen at capture, so later writes never reach queued fills.
  always_ff @(posedge clk_in) begin
    if (push) queue_q[wr_ptr_q] <= rsp_pkt;
    if (pop)  hold_pkt_p1       <= queue_q[rd_ptr_q];
  end

  assign to_mem_packet_ack_out = ack_p1;
  assign from_mem_packet_out   = (state_q == SEND) ? hold_pkt_p1 : '0;

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// Bench for unified_cache_mem_responder: directed steps plus random traffic
// checked against a block-store / FIFO reference model.
`timescale 1ns/1ps

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 69
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 68
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI 67
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO 65
`endif
`ifndef UNIFIED_CACHE_PACKET_IS_WRITE_POS
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS 64
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_HI
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI 63
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_POS_LO
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO 32
`endif
`ifndef UNIFIED_CACHE_PACKET_DATA_POS_LO
`define UNIFIED_CACHE_PACKET_DATA_POS_LO 0
`endif

module tb_unified_cache_mem_responder;
  localparam int NB  = 256;
  localparam int BS  = 4;
  localparam int LAT = 4;
  localparam int QD  = 4;
  localparam int PW  = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int VP  = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int WP  = `UNIFIED_CACHE_PACKET_IS_WRITE_POS;
  localparam int AHI = `UNIFIED_CACHE_PACKET_ADDR_POS_HI;
  localparam int ALO = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
  localparam int DLO = `UNIFIED_CACHE_PACKET_DATA_POS_LO;
  localparam int PHI = `UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI;
  localparam int PLO = `UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO;

  typedef logic [PW-1:0] pkt_t;

  logic  clk_in   = 1'b0;
  logic  reset_in = 1'b0;
  pkt_t  req      = '0;
  logic  req_ack;
  pkt_t  rsp;
  logic  rsp_ack  = 1'b0;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    rsp_count = 0;
  bit    ack_en   = 1'b0;
  bit    bp_rand  = 1'b0;
  bit    holding  = 1'b0;
  pkt_t  held     = '0;

  logic [31:0] model [NB];
  pkt_t        exp_q [$];

  unified_cache_mem_responder #(
    .NUM_BLOCKS                         (NB),
    .BLOCK_SIZE_IN_BYTES                (BS),
    .LATENCY                            (LAT),
    .QUEUE_DEPTH                        (QD),
    .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS (PW)
  ) dut (
    .clk_in                 (clk_in),
    .reset_in               (reset_in),
    .to_mem_packet_in       (req),
    .to_mem_packet_ack_out  (req_ack),
    .from_mem_packet_out    (rsp),
    .from_mem_packet_ack_in (rsp_ack)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input pkt_t obs, input pkt_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] addr, input bit wr,
                              input logic [31:0] data, input logic [2:0] port);
    pkt_t p = '0;
    p[VP]        = 1'b1;
    p[WP]        = wr;
    p[AHI:ALO]   = addr;
    p[DLO +: 32] = data;
    p[PHI:PLO]   = port;
    return p;
  endfunction

  // Reference: a flat block array indexed by address/blocksize modulo depth,
  // and an in-order list of fills, each frozen when its read is accepted.
  task automatic record(input pkt_t p);
    int idx;
    idx = int'((p[AHI:ALO] / BS) % NB);
    if (p[WP]) model[idx] = p[DLO +: 32];
    else       exp_q.push_back(mk(p[AHI:ALO], 1'b0, model[idx], p[PHI:PLO]));
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) model[i] = '0;
    exp_q.delete();
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic issue(input pkt_t p, output int ack_cyc);
    req     = p;
    ack_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (req_ack === 1'b1) begin
        ack_cyc = cyc;
        break;
      end
    end
    req = '0;
    checks++;
    assert (ack_cyc >= 0) else begin
      failures++;
      $error("FAIL req_ack_timeout observed=no_ack expected=ack addr=%h", p[AHI:ALO]);
    end
    if (ack_cyc >= 0) record(p);
  endtask

  task automatic wait_rsp_valid(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rsp[VP] === 1'b1) begin
        at_cyc = cyc;
        break;
      end
    end
    checks++;
    assert (at_cyc >= 0) else begin
      failures++;
      $error("FAIL rsp_valid_timeout observed=idle expected=valid");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp[VP] === 1'b1) && n < 1000) begin
      step();
      n++;
    end
    checks++;
    assert (n < 1000) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d_pending expected=0", exp_q.size());
    end
  endtask

  // Response-side consumer: checks each fill in order, its stability while
  // held, and that the idle bus is all-zero; acks when enabled.
  always @(negedge clk_in) begin
    rsp_ack = 1'b0;
    if (reset_in !== 1'b1) begin
      holding = 1'b0;
    end else if (rsp[VP] === 1'b1) begin
      if (holding) chk("rsp_hold_stable", rsp, held);
      else begin
        holding = 1'b1;
        held    = rsp;
      end
      if (ack_en && (!bp_rand || $urandom_range(0, 3) != 0)) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL rsp_unexpected observed=%h expected=none", rsp);
        end
        if (exp_q.size() != 0) chk("rsp_pkt", rsp, exp_q.pop_front());
        rsp_ack = 1'b1;
        holding = 1'b0;
        rsp_count++;
      end
    end else begin
      holding = 1'b0;
      chk("idle_zero", rsp, '0);
    end
  end

  initial begin
    int   c;
    int   rack;
    int   first;
    int   acks;
    int   seen;
    int   base;
    pkt_t p;
    logic [31:0] a;

    clear_model();
    reset_in = 1'b0;
    repeat (3) step();
    chk_bit("reset_ack", req_ack, 1'b0);
    chk("reset_rsp", rsp, '0);
    reset_in = 1'b1;
    step();
    chk_bit("post_reset_ack", req_ack, 1'b0);

    // Write then read with latency measurement.
    ack_en = 1'b1;
    issue(mk(32'h40, 1'b1, 32'hDEADBEEF, 3'd5), c);
    issue(mk(32'h40, 1'b0, 32'h0, 3'd5), rack);
    wait_rsp_valid(first);
    chk_int("read_latency", first - rack, LAT + 1);
    chk("wr_rd_fields", rsp, mk(32'h40, 1'b0, 32'hDEADBEEF, 3'd5));
    step();
    chk("zero_after_ack", rsp, '0);
    drain();

    // Read-before-write ordering.
    issue(mk(32'h80, 1'b1, 32'h11111111, 3'd1), c);
    issue(mk(32'h80, 1'b0, 32'h0, 3'd1), c);
    issue(mk(32'h80, 1'b1, 32'h22222222, 3'd2), c);
    issue(mk(32'h80, 1'b0, 32'h0, 3'd2), c);
    drain();
    issue(mk(32'h100, 1'b0, 32'h0, 3'd0), c);
    drain();

    // Queue full: one read moves into service, QD more fill the queue.
    ack_en = 1'b0;
    base   = rsp_count;
    for (int k = 0; k < QD + 1; k++)
      issue(mk(32'(k * BS + 32'h200), 1'b0, 32'h0, 3'(k)), c);
    p    = mk(32'h300, 1'b0, 32'h0, 3'd7);
    req  = p;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ack === 1'b1) acks++;
    end
    chk_int("qfull_no_ack", acks, 0);
    chk_bit("qfull_one_held", rsp[VP], 1'b1);
    ack_en = 1'b1;
    c = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (req_ack === 1'b1) begin
        c = i;
        break;
      end
    end
    req = '0;
    checks++;
    assert (c >= 0) else begin
      failures++;
      $error("FAIL qfull_late_ack observed=no_ack expected=ack");
    end
    if (c >= 0) record(p);
    drain();
    chk_int("qfull_rsp_total", rsp_count - base, QD + 2);

    // Backpressure and aliasing.
    a = $urandom;
    issue(mk(32'h40, 1'b1, a, 3'd3), c);
    ack_en = 1'b0;
    issue(mk(32'(NB * BS + 32'h40), 1'b0, 32'h0, 3'd2), c);
    wait_rsp_valid(first);
    for (int i = 0; i < 7; i++) begin
      chk("bp_alias_hold", rsp, mk(32'(NB * BS + 32'h40), 1'b0, a, 3'd2));
      step();
    end
    ack_en = 1'b1;
    drain();

    // Random traffic with random response backpressure.
    bp_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 7) * BS + $urandom_range(0, 1) * NB * BS + $urandom_range(0, BS - 1));
      issue(mk(a, 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7))), c);
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    bp_rand = 1'b0;

    // Asynchronous reset with reads outstanding.
    ack_en = 1'b0;
    issue(mk(32'h40, 1'b0, 32'h0, 3'd1), c);
    wait_rsp_valid(first);
    req = mk(32'h44, 1'b0, 32'h0, 3'd2);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (req_ack === 1'b1) begin
        c = i;
        break;
      end
    end
    chk_bit("pre_reset_ack_seen", (c >= 0), 1'b1);
    reset_in = 1'b0;
    #1;
    chk_bit("async_reset_ack", req_ack, 1'b0);
    chk("async_reset_rsp", rsp, '0);
    req = '0;
    clear_model();
    repeat (3) step();
    reset_in = 1'b1;
    ack_en   = 1'b1;
    seen     = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp[VP] !== 1'b0) seen++;
    end
    chk_int("no_rsp_after_reset", seen, 0);
    issue(mk(32'h40, 1'b0, 32'h0, 3'd6), c);
    issue(mk(32'(NB * BS + 32'h80), 1'b0, 32'h0, 3'd4), c);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
